// File: rtl/fetch_unit_pkg.sv
// Shared core constants and types for the instruction fetch path.
package fetch_unit_pkg;

    // Canonical NOP (addi x0, x0, 0) used to scrub buffer entries.
    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned FETCH_FIFO_DEPTH     = 2;

    // One buffered fetch: the PC it was fetched from and the instruction word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Fetches are always word aligned; low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between fetch and decode. Push and pop may occur
// in the same cycle (also when full); flush empties it in one cycle.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    fetch_entry_t     entries_q [DEPTH];
    fetch_entry_t     entries_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign head  = entries_q[rd_ptr_q];
    assign count = count_q;

    // Next-state: guard against underflow/overflow, then update pointers and count.
    always_comb begin
        entries_d = entries_q;
        valid_d   = valid_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_pop    = pop && valid_q[rd_ptr_q];
        do_push   = push && ((count_q < 2'(DEPTH)) || do_pop);
        if (flush) begin
            valid_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 2'd0;
        end else begin
            if (do_pop) begin
                valid_d[rd_ptr_q] = 1'b0;
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            // Applied after the pop so a full-FIFO push into the slot being freed stays valid.
            if (do_push) begin
                entries_d[wr_ptr_q] = push_entry;
                valid_d[wr_ptr_q]   = 1'b1;
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State register; reset scrubs every entry to a NOP at PC 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '{pc: 32'h0, instr: NOP_INSTR};
            end
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 2'd0;
        end else begin
            entries_q <= entries_d;
            valid_q   <= valid_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, bus request address, and a 2-entry buffer
// feeding decode. Redirect flushes the buffer and reloads the PC.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned FIFO_DEPTH   = FETCH_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] fetch_address,
    input  logic [31:0] fetch_data,
    input  logic        fetch_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    logic [31:0]  pc_q, pc_d;
    logic [1:0]   count;
    logic         push, pop;
    fetch_entry_t push_entry, head;

    // Address comes straight from the PC flop, so fetch_ready never reaches it.
    assign fetch_address = word_align(pc_q);
    assign out_instr     = head.instr;
    assign out_pc        = head.pc;

    // Handshakes and next PC; redirect outranks push and pop.
    always_comb begin
        out_valid  = reset && (count != 2'd0) && !redirect;
        pop        = out_valid && out_ready;
        push       = fetch_ready && !redirect && ((count < 2'(FIFO_DEPTH)) || pop);
        push_entry = '{pc: pc_q, instr: fetch_data};
        pc_d       = pc_q;
        if (redirect) begin
            pc_d = word_align(redirect_target);
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // PC register; reset wins over any in-flight fetch or redirect.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (head),
        .count      (count)
    );

endmodule
